gate_sweep_checker: RTL

Exhaustive stimulus-and-check stage for the two-input basic-gate block. It drives the gate block's `a`/`b` inputs through all four input combinations and samples its seven gate outputs after a programmable settle time. It compares each sample against a golden truth table and reports a pass flag, a per-vector failure map and a per-gate failure mask. It is used on-board and in simulation as the self-check wrapper around the gate block.

---
 rtl/gate_sweep_checker_pkg.sv | 35 +++
 rtl/gate_sweep_checker_if.sv | 33 +++
 rtl/gate_sweep_checker_expect.sv | 26 ++
 rtl/gate_sweep_checker.sv | 117 +++++++++++
 4 files changed

// File: rtl/gate_sweep_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gate_sweep_pkg
// Brief   : Shared constants, FSM state type and golden truth table for the
//           two-input gate sweep checker.
// Revision: 1.0
// ============================================================================
package gate_sweep_pkg;

    localparam int GATE_W = 7;

    // Bit positions of each gate inside the 7-bit gate word
    localparam int c_BIT_B_NOT = 6;
    localparam int c_BIT_AND   = 5;
    localparam int c_BIT_OR    = 4;
    localparam int c_BIT_NAND  = 3;
    localparam int c_BIT_NOR   = 2;
    localparam int c_BIT_XOR   = 1;
    localparam int c_BIT_XNOR  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Golden gate words for {a,b} = 00, 01, 10, 11
    localparam logic [GATE_W-1:0] c_EXP_V0 = 7'b1001101;
    localparam logic [GATE_W-1:0] c_EXP_V1 = 7'b0011010;
    localparam logic [GATE_W-1:0] c_EXP_V2 = 7'b1011010;
    localparam logic [GATE_W-1:0] c_EXP_V3 = 7'b0110001;

endpackage
`default_nettype wire

// File: rtl/gate_sweep_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : gate_sweep_checker_if
// Brief   : Stimulus, gate-sample and result bundle of the gate sweep checker.
// Revision: 1.0
// ============================================================================
interface gate_sweep_checker_if;
    import gate_sweep_pkg::*;

    logic              start;
    logic [GATE_W-1:0] gates_in;
    logic              a;
    logic              b;
    logic              busy;
    logic              done;
    logic              pass;
    logic [2:0]        err_count;
    logic [3:0]        err_vec;
    logic [GATE_W-1:0] err_mask;

    // master: the checker itself; slave: the environment around it
    modport master (
        input  start, gates_in,
        output a, b, busy, done, pass, err_count, err_vec, err_mask
    );

    modport slave (
        output start, gates_in,
        input  a, b, busy, done, pass, err_count, err_vec, err_mask
    );

endinterface
`default_nettype wire

// File: rtl/gate_sweep_checker_expect.sv
`default_nettype none
// ============================================================================
// Module  : gate_expect
// Brief   : Golden model lookup: expected 7-bit gate word for a vector index,
//           taken from table constants rather than re-derived gate logic.
// Revision: 1.0
// ============================================================================
module gate_expect
    import gate_sweep_pkg::*;
(
    input  wire logic [1:0]        i_idx,
    output logic      [GATE_W-1:0] o_expect
);

    always_comb begin
        o_expect = c_EXP_V0;
        unique case (i_idx)
            2'd0: o_expect = c_EXP_V0;
            2'd1: o_expect = c_EXP_V1;
            2'd2: o_expect = c_EXP_V2;
            2'd3: o_expect = c_EXP_V3;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module  : gate_sweep_checker
// Brief   : Sweeps a/b through all four vectors, samples the gate block after
//           SETTLE cycles and accumulates pass / per-vector / per-gate results.
// Revision: 1.0
// ============================================================================
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter bit LOOP   = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    gate_sweep_checker_if.master sweep
);

    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);

    state_t            r_state;
    logic [1:0]        r_idx;
    logic [3:0]        r_wait;
    logic [2:0]        r_err_count;
    logic [3:0]        r_err_vec;
    logic [GATE_W-1:0] r_err_mask;
    logic              r_pass;
    logic              r_done;

    logic [GATE_W-1:0] w_expect;
    logic [GATE_W-1:0] w_mism;
    logic              w_hit;
    logic [3:0]        w_err_vec_next;

    gate_expect u_expect (
        .i_idx    (r_idx),
        .o_expect (w_expect)
    );

    assign w_mism         = sweep.gates_in ^ w_expect;
    assign w_hit          = |w_mism;
    // Includes the current vector so DONE sees the final map in one cycle
    assign w_err_vec_next = r_err_vec | (4'(w_hit) << r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_wait      <= 4'd0;
            r_err_count <= 3'd0;
            r_err_vec   <= 4'd0;
            r_err_mask  <= '0;
            r_pass      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (sweep.start) begin
                        r_err_count <= 3'd0;
                        r_err_vec   <= 4'd0;
                        r_err_mask  <= '0;
                        r_idx       <= 2'd0;
                        r_wait      <= 4'd0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait == c_SETTLE_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (w_hit) begin
                        r_err_vec   <= w_err_vec_next;
                        r_err_count <= r_err_count + 3'd1;
                        r_err_mask  <= r_err_mask | w_mism;
                    end
                    if (r_idx == 2'd3) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_vec_next == 4'd0);
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_wait  <= 4'd0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (LOOP) begin
                        r_err_count <= 3'd0;
                        r_err_vec   <= 4'd0;
                        r_err_mask  <= '0;
                        r_idx       <= 2'd0;
                        r_wait      <= 4'd0;
                        r_state     <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign sweep.a         = r_idx[1];
    assign sweep.b         = r_idx[0];
    assign sweep.busy      = (r_state != ST_IDLE);
    assign sweep.done      = r_done;
    assign sweep.pass      = r_pass;
    assign sweep.err_count = r_err_count;
    assign sweep.err_vec   = r_err_vec;
    assign sweep.err_mask  = r_err_mask;

endmodule
`default_nettype wire
